// File: rtl/debounce_pulse_gen_if.sv
// Button-conditioning bus: raw button in, debounced level, press strobe and busy flag out.
interface debounce_pulse_gen_if;
    logic btn_in;
    logic pulse_out;
    logic level_out;
    logic busy;

    modport master (
        output btn_in,
        input  pulse_out,
        input  level_out,
        input  busy
    );

    modport slave (
        input  btn_in,
        output pulse_out,
        output level_out,
        output busy
    );
endinterface

// File: rtl/debounce_pulse_gen.sv
// Synchronises and debounces a push button, emitting one pulse per accepted press.
// Optional auto-repeat while held is compiled in with `define DEBOUNCE_AUTOREPEAT_EN.
module debounce_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input logic                 clk,
    input logic                 rst,
    debounce_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        HELD,
        ARM_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pulse;
    logic             level;
    logic             busy_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    typedef enum logic {
        PH_DELAY,
        PH_PERIOD
    } phase_t;

    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt;
    phase_t           phase;
`else
    // Repeat timing parameters stay in the parameter list so callers can override them in either build.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_cfg_unused
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    assign btn_sync = sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pulse  <= 1'b0;
            level  <= 1'b0;
            busy_q <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_cnt <= '0;
            phase   <= PH_DELAY;
`endif
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state  <= ARM_PRESS;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end

                ARM_PRESS: begin
                    if (!btn_sync) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == DB_LAST) begin
                        state  <= HELD;
                        cnt    <= '0;
                        level  <= 1'b1;
                        pulse  <= 1'b1;
                        busy_q <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        rep_cnt <= '0;
                        phase   <= PH_DELAY;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    // Repeat timing runs on every HELD cycle; the count survives ARM_RELEASE bounces.
                    if (phase == PH_DELAY && rep_cnt == REP_DELAY_LAST) begin
                        pulse   <= 1'b1;
                        rep_cnt <= '0;
                        phase   <= PH_PERIOD;
                    end else if (phase == PH_PERIOD && rep_cnt == REP_PERIOD_LAST) begin
                        pulse   <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_ONE;
                    end
`endif
                    if (!btn_sync) begin
                        state  <= ARM_RELEASE;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end

                ARM_RELEASE: begin
                    if (btn_sync) begin
                        state  <= HELD;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == DB_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        level  <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    level  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_out = pulse;
    assign bus.level_out = level;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed bench for debounce_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_debounce_pulse_gen;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [3:0] press_count;

    debounce_pulse_gen_if bus ();

    debounce_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_outs(input string tag, input logic p, input logic l, input logic b);
        check({tag, " pulse"}, {3'b0, bus.pulse_out}, {3'b0, p});
        check({tag, " level"}, {3'b0, bus.level_out}, {3'b0, l});
        check({tag, " busy"},  {3'b0, bus.busy},      {3'b0, b});
    endtask

    // Expected pulse after edge e of a steady press (edge 1 = first edge sampling btn_in=1).
    function automatic logic exp_pulse(input int e);
        if (e == 6) return 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (e >= 14 && ((e - 14) % 3) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    initial begin
        logic bounce_pat [12];
        logic glitch_pat [12];
        checks      = 0;
        failures    = 0;
        press_count = '0;
        bounce_pat  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        glitch_pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.btn_in = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        tick();
        check_outs("idle", 1'b0, 1'b0, 1'b0);

        // Clean press held long, then clean release
        bus.btn_in = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            check_outs($sformatf("press e%0d", e), exp_pulse(e), e >= 6, e >= 3 && e <= 5);
        end
        bus.btn_in = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            tick();
            check_outs($sformatf("release r%0d", r), r <= 2 && exp_pulse(30 + r), r < 6, r >= 3 && r <= 5);
        end

        // Bounce shorter than the debounce window
        for (int i = 0; i < 12; i++) begin
            bus.btn_in = bounce_pat[i];
            tick();
            check($sformatf("bounce pulse i%0d", i), {3'b0, bus.pulse_out}, 4'd0);
            check($sformatf("bounce level i%0d", i), {3'b0, bus.level_out}, 4'd0);
        end
        check("bounce idle busy", {3'b0, bus.busy}, 4'd0);

        // Press, then release with a one-cycle glitch high
        bus.btn_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_outs($sformatf("gpress e%0d", e), e == 6, e >= 6, e >= 3 && e <= 5);
        end
        for (int i = 0; i < 12; i++) begin
            bus.btn_in = glitch_pat[i];
            tick();
            check($sformatf("glitch pulse i%0d", i), {3'b0, bus.pulse_out}, 4'd0);
            check($sformatf("glitch level i%0d", i), {3'b0, bus.level_out}, {3'b0, i < 8});
        end

        // Async reset mid-debounce (cnt=3), then mid-HELD; button stays high across both
        bus.btn_in = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        check("pre-reset busy", {3'b0, bus.busy}, 4'd1);
        for (int k = 0; k < 2; k++) begin
            #2 rst = 1'b1;
            #1;
            check_outs($sformatf("async reset k%0d", k), 1'b0, 1'b0, 1'b0);
            #2 rst = 1'b0;
            for (int f = 1; f <= 8; f++) begin
                tick();
                check_outs($sformatf("post-reset k%0d f%0d", k, f), f == 6, f >= 6, f >= 3 && f <= 5);
            end
        end
        bus.btn_in = 1'b0;
        for (int r = 1; r <= 8; r++) tick();
        check("post-reset released", {3'b0, bus.level_out}, 4'd0);

        // Back-to-back presses separated by 6 low cycles feed a 4-bit counter
        for (int p = 0; p < 2; p++) begin
            bus.btn_in = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                tick();
                press_count = press_count + {3'b0, bus.pulse_out};
                check_outs($sformatf("b2b p%0d e%0d", p, e), e == 6, e >= 6, e >= 3 && e <= 5);
            end
            bus.btn_in = 1'b0;
            for (int g = 1; g <= 6; g++) begin
                tick();
                press_count = press_count + {3'b0, bus.pulse_out};
                check_outs($sformatf("b2b p%0d g%0d", p, g), 1'b0, g < 6, g >= 3 && g <= 5);
            end
        end
        check("b2b counter", press_count, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
